effect_limiter: RTL and testbench
=================================

# effect_limiter

Peak limiter that is the last stage of the effect chain, directly downstream of the chorus stage and feeding the codec DAC path. It accepts one signed 16-bit sample per `i_valid` pulse and tracks a peak envelope with hold and release. When the envelope exceeds a threshold selected by `i_level`, it computes a gain with a sequential divider and scales the sample. The block has fixed latency, so the chain sample cadence is preserved.

## Interface
- `HOLD_SAMPLES`, default 480: samples the envelope is held after a new peak (10 ms at 48 kHz).
- `RELEASE_SHIFT`, default 10: envelope decay per sample is `max(env >> RELEASE_SHIFT, 1)`.
- `ATTACK_SHIFT`, default 0: envelope rise per sample is `(abs - env) >> ATTACK_SHIFT`. With 0, the envelope jumps to the peak immediately.
- `i_clk`  in  1: the single clock.
- `i_rst`  in  1: reset, synchronous and active-high.
- `i_valid`  in  1: one-cycle sample strobe.
- `i_enable`  in  1: 1 = limiting active, 0 = bypass.
- `i_level`  in  3: threshold select, `T = 32767 - 4096*i_level` (level 0 → 32767, level 7 → 4095).
- `i_data`  in  16 signed: input sample.
- `o_data`  out  16 signed: output sample, registered.
- `o_valid`  out  1: one-cycle strobe, registered.

## Operation
- State machine: IDLE → ENV (1 cycle) → DIV (16 cycles) → MUL (1 cycle) → IDLE.
- IDLE:
  - On `i_valid=1`, latch `x=i_data`, `en=i_enable` and `T` from `i_level`.
  - `i_enable` and `i_level` are sampled only at this point.
- ENV:
  - Compute `abs = |x|`, saturating (-32768 → 32767).
  - If `abs > env`: `env += (abs-env) >> ATTACK_SHIFT` and reload `hold = HOLD_SAMPLES`.
  - Else if `hold > 0`: `hold -= 1`.
  - Else if `env > 0`: `env -= max(env >> RELEASE_SHIFT, 1)`.
  - `env` is 16-bit unsigned and never underflows.
  - The envelope updates even when `en=0`, so enabling the limiter causes no gain jump.
- DIV:
  - Always occupies 16 cycles, for fixed latency.
  - If `en=1` and `env > T`: gain `g = floor(T*32768 / env)` via restoring division. `g` is always < 32768.
  - Otherwise `g = 32768` (unity). `g` is 17-bit unsigned.
- MUL:
  - `o_data <= (x * g) >>> 15`, using a signed 33-bit product and an arithmetic shift (floor).
  - With `g = 32768`, `o_data = x` exactly, including -32768.
  - `o_valid <= 1` for the next cycle only.
- `i_valid` pulses arriving in ENV, DIV or MUL are ignored; the sample is dropped and nothing is queued.
- Each accepted sample produces exactly one `o_valid` pulse.

## Timing
- Latency: sample accepted in cycle 0 (IDLE with `i_valid=1`).
  - ENV in cycle 1, DIV in cycles 2–17, MUL in cycle 18.
  - `o_valid=1` with the new `o_data` in cycle 19; the state is IDLE in cycle 19.
- A new `i_valid` in cycle 19 is accepted; minimum input spacing is 19 cycles.
  - At 50 MHz and 48 kHz the real spacing is about 1041 cycles.
- `o_data` holds its value between `o_valid` pulses.
- Reset values:
  - `o_data=0`, `o_valid=0`.
  - `env=0`, `hold=0`, `g=32768`, state IDLE.
- Reset mid-operation abandons the sample: no `o_valid` is produced, and the first post-reset output uses an envelope that starts from 0.
- Reset has priority over `i_valid` in the same cycle.

## Test plan
- Reset:
  - Assert `i_rst` for 2 cycles during DIV of a sample → `o_valid` never pulses for that sample; `o_data=0`.
  - After reset, `i_enable=0`, x=1234 → `o_data=1234` in cycle 19.
- Bypass:
  - `i_enable=0`, `i_level=7`, x=30000 → `o_data=30000`.
  - x=-32768 → `o_data=-32768`.
  - In both cases `o_valid` is exactly one cycle, 19 cycles after acceptance.
- Below threshold:
  - `i_enable=1`, `i_level=7` (T=4095), x=2000 repeated 5 times from reset → `o_data=2000` each time.
- Limiting (defaults, `i_level=4`, T=16383, from reset):
  - x=32767 → env=32767, g=16383, `o_data=16382`.
  - Next x=-32768 → `o_data=-16383`.
- Hold/release:
  - After x=32767 with `HOLD_SAMPLES=480`, feed zeros → env stays 32767 for 480 samples.
  - The next zero sample sets env=32736; env then decreases monotonically to 0 and never wraps.
- Drop rule:
  - `i_valid` pulses in cycles 0, 5 and 18 → exactly one `o_valid` (cycle 19), carrying the cycle-0 sample.
  - A pulse in cycle 19 is accepted → second `o_valid` in cycle 38.

Source files
------------

// File: rtl/effect_limiter.sv
// effect_limiter: peak limiter, last stage of the effect chain.
// Tracks a peak envelope with hold and release. When limiting is enabled and
// the envelope is above the level-selected threshold, a gain
// g = floor(T*32768/env) is formed by a 16-step restoring divider and the
// sample is scaled by it. Latency is fixed at 19 cycles whether or not the
// sample is limited.
//
// Ports:
//   i_clk     clock
//   i_rst     synchronous active-high reset
//   i_valid   one-cycle input sample strobe (ignored while busy)
//   i_enable  1 = limiting active, 0 = bypass (sampled on acceptance)
//   i_level   threshold select, T = 32767 - 4096*i_level (sampled on acceptance)
//   i_data    signed 16-bit input sample
//   o_data    signed 16-bit output sample, registered, held between strobes
//   o_valid   one-cycle output strobe, registered
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for i_valid; latches sample, enable and threshold
// ENV   | envelope attack / hold / release update, divider setup
// DIV   | 16 restoring-division steps, gain selected on the last step
// MUL   | sample * gain, arithmetic shift by 15, output strobe

module effect_limiter #(
   parameter int HOLD_SAMPLES  = 480,
   parameter int RELEASE_SHIFT = 10,
   parameter int ATTACK_SHIFT  = 0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   input  logic               i_enable,
   input  logic [2:0]         i_level,
   input  logic signed [15:0] i_data,
   output logic signed [15:0] o_data,
   output logic               o_valid
);

   localparam int HOLD_W = (HOLD_SAMPLES < 1) ? 1 : $clog2(HOLD_SAMPLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENV,
      S_DIV,
      S_MUL
   } state_t;

   state_t              state;
   logic signed [15:0]  x_q;
   logic                en_q;
   logic [14:0]         thr_q;
   logic [15:0]         env_q;
   logic [HOLD_W-1:0]   hold_q;
   logic [16:0]         g_q;
   logic [3:0]          div_cnt;
   logic [15:0]         rem_q;
   logic [15:0]         dlo_q;
   logic [14:0]         quo_q;

   logic [15:0]         abs_x;
   logic [15:0]         rise;
   logic [15:0]         decay;
   logic [16:0]         rem_shift;
   logic                rem_ge;
   logic                limit;
   logic signed [32:0]  prod;

   always_comb begin
      abs_x = x_q[15] ? 16'(-x_q) : 16'(x_q);
      if (x_q == 16'sh8000) begin
         abs_x = 16'h7fff;
      end

      rise  = (abs_x - env_q) >> ATTACK_SHIFT;
      decay = env_q >> RELEASE_SHIFT;
      if (decay == 16'd0) begin
         decay = 16'd1;
      end

      // One restoring step: bring down the next dividend bit, subtract if it fits.
      rem_shift = {rem_q, dlo_q[15]};
      rem_ge    = (rem_shift >= {1'b0, env_q});

      limit = en_q && (env_q > {1'b0, thr_q});

      prod = $signed({{17{x_q[15]}}, x_q}) * $signed({16'd0, g_q});
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= S_IDLE;
         x_q     <= '0;
         en_q    <= 1'b0;
         thr_q   <= '0;
         env_q   <= '0;
         hold_q  <= '0;
         g_q     <= 17'h08000;
         div_cnt <= '0;
         rem_q   <= '0;
         dlo_q   <= '0;
         quo_q   <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  x_q   <= i_data;
                  en_q  <= i_enable;
                  // 32767 - 4096*level: the top three bits are 7-level, the rest all ones.
                  thr_q <= {~i_level, 12'hfff};
                  state <= S_ENV;
               end
            end

            S_ENV: begin
               if (abs_x > env_q) begin
                  env_q  <= env_q + rise;
                  hold_q <= HOLD_W'(HOLD_SAMPLES);
               end else if (hold_q != '0) begin
                  hold_q <= hold_q - 1'b1;
               end else if (env_q != 16'd0) begin
                  env_q <= env_q - decay;
               end
               // Dividend is T*2^15. Its top bits (T>>1) are already below env
               // whenever limiting applies, so only the low 16 quotient bits
               // need computing.
               rem_q   <= {2'b00, thr_q[14:1]};
               dlo_q   <= {thr_q[0], 15'd0};
               quo_q   <= '0;
               div_cnt <= 4'd15;
               state   <= S_DIV;
            end

            S_DIV: begin
               rem_q <= rem_ge ? 16'(rem_shift - {1'b0, env_q}) : rem_shift[15:0];
               dlo_q <= {dlo_q[14:0], 1'b0};
               quo_q <= {quo_q[13:0], rem_ge};
               if (div_cnt == 4'd0) begin
                  g_q   <= limit ? {1'b0, quo_q, rem_ge} : 17'h08000;
                  state <= S_MUL;
               end else begin
                  div_cnt <= div_cnt - 4'd1;
               end
            end

            S_MUL: begin
               o_data  <= 16'(prod >>> 15);
               o_valid <= 1'b1;
               state   <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_effect_limiter.sv
module tb_effect_limiter;

   localparam int HOLD = 480;
   localparam int REL  = 10;
   localparam int ATK  = 0;

   logic               clk;
   logic               rst;
   logic               valid_in;
   logic               enable;
   logic [2:0]         level;
   logic signed [15:0] data_in;
   logic signed [15:0] data_out;
   logic               valid_out;

   int checks;
   int errors;
   int env_m;
   int hold_m;

   effect_limiter #(
      .HOLD_SAMPLES (HOLD),
      .RELEASE_SHIFT(REL),
      .ATTACK_SHIFT (ATK)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (valid_in),
      .i_enable(enable),
      .i_level (level),
      .i_data  (data_in),
      .o_data  (data_out),
      .o_valid (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

   // Reference: envelope follower and limiter gain straight from the rules.
   function automatic int model_step(input int x, input bit en, input int lvl);
      int     a;
      int     t;
      int     d;
      longint g;
      longint p;
      a = (x < 0) ? -x : x;
      if (a > 32767) a = 32767;
      if (a > env_m) begin
         env_m  = env_m + ((a - env_m) >> ATK);
         hold_m = HOLD;
      end else if (hold_m > 0) begin
         hold_m = hold_m - 1;
      end else if (env_m > 0) begin
         d = env_m >> REL;
         if (d < 1) d = 1;
         env_m = env_m - d;
      end
      t = 32767 - 4096 * lvl;
      if (en && env_m > t) begin
         g = (longint'(t) * 32768) / env_m;
         p = longint'(x) * g;
         return int'(p >>> 15);
      end
      return x;
   endfunction

   // Called at a negedge (cycle 0). Returns at the negedge of cycle 19.
   task automatic send_sample(input int x, input bit en, input int lvl, input string tag);
      int exp;
      int early;
      exp      = model_step(x, en, lvl);
      valid_in = 1'b1;
      data_in  = 16'(x);
      enable   = en;
      level    = 3'(lvl);
      early    = 0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c == 1) valid_in = 1'b0;
         if (c < 19 && valid_out !== 1'b0) early++;
      end
      checks++;
      if (valid_out !== 1'b1 || early != 0) begin
         errors++;
         $display("FAIL %s_valid: o_valid at cycle 19 = %b, early pulses = %0d, required 1 and 0",
                  tag, valid_out, early);
      end
      checks++;
      if (data_out !== 16'(exp)) begin
         errors++;
         $display("FAIL %s_data: x=%0d en=%0d lvl=%0d o_data=%0d required %0d",
                  tag, x, en, lvl, data_out, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      env_m  = 0;
      hold_m = 0;
   endtask

   task automatic test_reset();
      int pulses;
      // Reset asserted together with a valid strobe.
      rst      = 1'b1;
      valid_in = 1'b1;
      data_in  = 16'sd777;
      enable   = 1'b0;
      level    = 3'd0;
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      valid_in = 1'b0;
      env_m    = 0;
      hold_m   = 0;
      checks++;
      if (data_out !== 16'sd0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: o_data=%0d o_valid=%b required 0 and 0", data_out, valid_out);
      end
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (valid_out !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_priority: o_valid pulses=%0d required 0", pulses);
      end

      // Reset during DIV abandons the sample.
      valid_in = 1'b1;
      data_in  = 16'sd32767;
      enable   = 1'b1;
      level    = 3'd4;
      pulses   = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (c == 1) valid_in = 1'b0;
         if (c == 5) rst = 1'b1;
         if (c == 7) rst = 1'b0;
         if (valid_out !== 1'b0) pulses++;
      end
      env_m  = 0;
      hold_m = 0;
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid_div_valid: o_valid pulses=%0d required 0", pulses);
      end
      checks++;
      if (data_out !== 16'sd0) begin
         errors++;
         $display("FAIL reset_mid_div_data: o_data=%0d required 0", data_out);
      end
      send_sample(1234, 1'b0, 7, "post_reset_bypass");
      send_sample(3000, 1'b1, 7, "post_reset_env");
   endtask

   task automatic test_bypass();
      do_reset();
      send_sample(30000, 1'b0, 7, "bypass_pos");
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL bypass_pos_width: o_valid at cycle 20 = %b required 0", valid_out);
      end
      send_sample(-32768, 1'b0, 7, "bypass_min");
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL bypass_min_width: o_valid at cycle 20 = %b required 0", valid_out);
      end
   endtask

   task automatic test_below_threshold();
      do_reset();
      repeat (5) send_sample(2000, 1'b1, 7, "below_thr");
   endtask

   task automatic test_limiting();
      do_reset();
      send_sample(32767, 1'b1, 4, "limit_peak");
      send_sample(-32768, 1'b1, 4, "limit_neg");
   endtask

   // Probes never exceed the envelope, so the outputs expose the envelope
   // through the gain without disturbing hold or release.
   task automatic test_hold_release();
      int x;
      do_reset();
      send_sample(32767, 1'b1, 4, "hr_peak");
      for (int k = 1; k <= HOLD + 300; k++) begin
         if (k % 7 == 3) x = 0;
         else x = ($urandom_range(0, 1) == 1) ? -env_m : env_m;
         send_sample(x, 1'b1, 4, (k <= HOLD) ? "hr_hold" : "hr_release");
      end
   endtask

   task automatic test_decay_to_zero();
      do_reset();
      send_sample(300, 1'b1, 7, "dz_peak");
      repeat (HOLD + 300 + 5) send_sample(0, 1'b1, 7, "dz_zero");
      send_sample(3000, 1'b1, 7, "dz_nowrap");
   endtask

   task automatic test_drop();
      int a;
      int b;
      int c18;
      int d;
      int exp_a;
      int exp_d;
      int bad;
      a     = int'($urandom_range(0, 65535)) - 32768;
      b     = int'($urandom_range(0, 65535)) - 32768;
      c18   = int'($urandom_range(0, 65535)) - 32768;
      d     = int'($urandom_range(0, 65535)) - 32768;
      exp_a = model_step(a, 1'b1, 5);
      exp_d = 0;
      bad   = 0;
      enable = 1'b1;
      level  = 3'd5;
      for (int c = 0; c <= 38; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (valid_out !== ((c == 19 || c == 38) ? 1'b1 : 1'b0)) bad++;
            if (c == 19) begin
               checks++;
               if (data_out !== 16'(exp_a)) begin
                  errors++;
                  $display("FAIL drop_first_data: o_data=%0d required %0d", data_out, exp_a);
               end
               exp_d = model_step(d, 1'b1, 5);
            end
            if (c == 38) begin
               checks++;
               if (data_out !== 16'(exp_d)) begin
                  errors++;
                  $display("FAIL drop_second_data: o_data=%0d required %0d", data_out, exp_d);
               end
            end
         end
         valid_in = (c == 0 || c == 5 || c == 18 || c == 19);
         case (c)
            0:       data_in = 16'(a);
            5:       data_in = 16'(b);
            18:      data_in = 16'(c18);
            19:      data_in = 16'(d);
            default: data_in = 16'sd0;
         endcase
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL drop_valid_pattern: wrong o_valid cycles=%0d required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int x;
      do_reset();
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 5))
            0:       x = -32768;
            1:       x = 32767;
            default: x = int'($urandom_range(0, 65535)) - 32768;
         endcase
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_sample(x, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), "random");
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      env_m    = 0;
      hold_m   = 0;
      rst      = 1'b1;
      valid_in = 1'b0;
      enable   = 1'b0;
      level    = 3'd0;
      data_in  = 16'sd0;
      @(negedge clk);
      test_reset();
      test_bypass();
      test_below_threshold();
      test_limiting();
      test_drop();
      test_hold_release();
      test_decay_to_zero();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
